// File: rtl/systolic_pe_pkg.sv
// Shared definitions for the systolic PE: FSM encoding, default widths and
// the saturation-bound helper used by the requantiser.
package systolic_pe_pkg;

  localparam int PE_DWIDTH = 8;
  localparam int PE_AWIDTH = 32;
  localparam int PE_SHW    = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } pe_state_e;

  // Lower/upper clamp value for a dw-bit result, signed or unsigned.
  function automatic logic signed [63:0] sat_bound(input int dw, input logic is_signed,
                                                   input logic upper);
    logic signed [63:0] one;
    one = 64'sd1;
    if (is_signed) begin
      return upper ? ((one <<< (dw - 1)) - one) : -(one <<< (dw - 1));
    end
    return upper ? ((one <<< dw) - one) : 64'sd0;
  endfunction

endpackage

// File: rtl/systolic_pe_acc_if.sv
// Data/config bundle of one systolic PE: west/north operands in, east/south
// forwarded operands and the requantised result out.
interface systolic_pe_acc_if
  import systolic_pe_pkg::*;
#(
  parameter int DWIDTH = PE_DWIDTH,
  parameter int SHW    = PE_SHW
);
  logic              cfg_signed;
  logic [SHW-1:0]    cfg_shift;
  logic              cfg_clear;
  logic              in_valid;
  logic [DWIDTH-1:0] in_a;
  logic [DWIDTH-1:0] in_b;
  logic              in_last;
  logic              out_valid;
  logic [DWIDTH-1:0] out_a;
  logic [DWIDTH-1:0] out_b;
  logic              out_last;
  logic              out_c_valid;
  logic [DWIDTH-1:0] out_c;
  logic              out_ovf;
  logic              out_sat;

  modport master (
    output cfg_signed, cfg_shift, cfg_clear, in_valid, in_a, in_b, in_last,
    input  out_valid, out_a, out_b, out_last, out_c_valid, out_c, out_ovf, out_sat
  );

  modport slave (
    input  cfg_signed, cfg_shift, cfg_clear, in_valid, in_a, in_b, in_last,
    output out_valid, out_a, out_b, out_last, out_c_valid, out_c, out_ovf, out_sat
  );
endinterface

// File: rtl/pe_requant.sv
// Combinational requantiser: round half-up, shift right, clamp AWIDTH -> DWIDTH.
// Works at AWIDTH+1 bits so the rounding increment can never wrap.
module pe_requant
  import systolic_pe_pkg::*;
#(
  parameter int DWIDTH = PE_DWIDTH,
  parameter int AWIDTH = PE_AWIDTH,
  parameter int SHW    = PE_SHW
) (
  input  logic [AWIDTH-1:0] sum,
  input  logic              is_signed,
  input  logic [SHW-1:0]    shift,
  output logic [DWIDTH-1:0] res,
  output logic              sat
);
  localparam int RW = AWIDTH + 1;

  logic signed [RW-1:0] sum_ext;
  logic signed [RW-1:0] rnd;
  logic signed [RW-1:0] biased;
  logic signed [RW-1:0] shifted;
  logic signed [RW-1:0] lo;
  logic signed [RW-1:0] hi;
  logic                 big_shift;

  assign sum_ext   = {is_signed & sum[AWIDTH-1], sum};
  assign lo        = RW'(sat_bound(DWIDTH, is_signed, 1'b0));
  assign hi        = RW'(sat_bound(DWIDTH, is_signed, 1'b1));
  // A shift wider than the accumulator always rounds to exactly zero.
  assign big_shift = 32'(shift) > AWIDTH;

  // Round, shift (arithmetic when signed, logical when unsigned) and clamp.
  always_comb begin
    rnd = '0;
    if (shift != '0 && !big_shift) begin
      rnd = RW'(1) << (shift - 1'b1);
    end
    biased = sum_ext + rnd;
    if (big_shift) begin
      shifted = '0;
    end else if (is_signed) begin
      shifted = biased >>> shift;
    end else begin
      shifted = biased >> shift;
    end
    sat = 1'b0;
    res = shifted[DWIDTH-1:0];
    if (shifted > hi) begin
      sat = 1'b1;
      res = hi[DWIDTH-1:0];
    end else if (shifted < lo) begin
      sat = 1'b1;
      res = lo[DWIDTH-1:0];
    end
  end
endmodule

// File: rtl/systolic_pe_acc.sv
// Systolic PE: forwards A east / B south, multiplies (S1), accumulates a
// vector closed by in_last (S2) and emits a requantised result (S3).
module systolic_pe_acc
  import systolic_pe_pkg::*;
#(
  parameter int DWIDTH = PE_DWIDTH,
  parameter int AWIDTH = PE_AWIDTH,
  parameter int SHW    = PE_SHW
) (
  input  logic             clk,
  input  logic             reset,
  systolic_pe_acc_if.slave bus
);
  localparam int PW = 2 * DWIDTH;

  // forward path
  logic              out_valid_reg;
  logic [DWIDTH-1:0] out_a_reg;
  logic [DWIDTH-1:0] out_b_reg;
  logic              out_last_reg;
  // S1
  logic [PW-1:0]     a_ext;
  logic [PW-1:0]     b_ext;
  logic [PW-1:0]     prod;
  logic [PW-1:0]     p_reg;
  logic              p_valid_reg;
  logic              p_last_reg;
  // S2
  pe_state_e         state_reg, state_next;
  logic [AWIDTH-1:0] acc_reg, acc_next;
  logic              ovf_reg, ovf_next;
  logic [AWIDTH-1:0] sum_reg, sum_next;
  logic              sum_valid_reg, sum_valid_next;
  logic              sum_ovf_reg, sum_ovf_next;
  logic [AWIDTH-1:0] p_ext;
  logic [AWIDTH-1:0] base;
  logic [AWIDTH-1:0] add_sum;
  logic              add_carry;
  logic              add_ovf;
  // S3
  logic [DWIDTH-1:0] req_res;
  logic              req_sat;
  logic              out_c_valid_reg;
  logic [DWIDTH-1:0] out_c_reg;
  logic              out_ovf_reg;
  logic              out_sat_reg;

  // Forwarded operands: valid always follows, data holds across idle cycles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid_reg <= 1'b0;
      out_a_reg     <= '0;
      out_b_reg     <= '0;
      out_last_reg  <= 1'b0;
    end else begin
      out_valid_reg <= bus.in_valid;
      if (bus.in_valid) begin
        out_a_reg    <= bus.in_a;
        out_b_reg    <= bus.in_b;
        out_last_reg <= bus.in_last;
      end
    end
  end

  // Extending both operands to the product width gives the right low
  // 2*DWIDTH bits for either signedness.
  assign a_ext = {{DWIDTH{bus.cfg_signed & bus.in_a[DWIDTH-1]}}, bus.in_a};
  assign b_ext = {{DWIDTH{bus.cfg_signed & bus.in_b[DWIDTH-1]}}, bus.in_b};
  assign prod  = a_ext * b_ext;

  // Product stage; a clear drops both the staged product and any new input.
  always_ff @(posedge clk) begin
    if (!reset) begin
      p_valid_reg <= 1'b0;
      p_last_reg  <= 1'b0;
      p_reg       <= '0;
    end else if (bus.cfg_clear) begin
      p_valid_reg <= 1'b0;
    end else begin
      p_valid_reg <= bus.in_valid;
      if (bus.in_valid) begin
        p_reg      <= prod;
        p_last_reg <= bus.in_last;
      end
    end
  end

  // Sign/zero-extend the product and form base + p_ext with overflow detect.
  always_comb begin
    p_ext             = {AWIDTH{bus.cfg_signed & p_reg[PW-1]}};
    p_ext[PW-1:0]     = p_reg;
    base              = (state_reg == ACCUM) ? acc_reg : '0;
    {add_carry, add_sum} = {1'b0, base} + {1'b0, p_ext};
    if (bus.cfg_signed) begin
      add_ovf = (base[AWIDTH-1] == p_ext[AWIDTH-1]) &&
                (add_sum[AWIDTH-1] != base[AWIDTH-1]);
    end else begin
      add_ovf = add_carry;
    end
  end

  // Accumulator FSM state and result-capture registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      ovf_reg       <= 1'b0;
      sum_reg       <= '0;
      sum_valid_reg <= 1'b0;
      sum_ovf_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      ovf_reg       <= ovf_next;
      sum_reg       <= sum_next;
      sum_valid_reg <= sum_valid_next;
      sum_ovf_reg   <= sum_ovf_next;
    end
  end

  // Accumulator FSM: open/extend a vector, close it on p_last, flush on clear.
  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    ovf_next       = ovf_reg;
    sum_next       = sum_reg;
    sum_valid_next = 1'b0;
    sum_ovf_next   = sum_ovf_reg;
    if (bus.cfg_clear) begin
      state_next = IDLE;
      acc_next   = '0;
      ovf_next   = 1'b0;
    end else if (p_valid_reg) begin
      if (p_last_reg) begin
        sum_next       = add_sum;
        sum_valid_next = 1'b1;
        sum_ovf_next   = ovf_reg | add_ovf;
        acc_next       = '0;
        ovf_next       = 1'b0;
        state_next     = IDLE;
      end else begin
        acc_next   = add_sum;
        ovf_next   = ovf_reg | add_ovf;
        state_next = ACCUM;
      end
    end
  end

  pe_requant #(
    .DWIDTH(DWIDTH),
    .AWIDTH(AWIDTH),
    .SHW   (SHW)
  ) u_requant (
    .sum      (sum_reg),
    .is_signed(bus.cfg_signed),
    .shift    (bus.cfg_shift),
    .res      (req_res),
    .sat      (req_sat)
  );

  // Result register: pulses valid for one cycle, data/flags hold otherwise.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_c_valid_reg <= 1'b0;
      out_c_reg       <= '0;
      out_ovf_reg     <= 1'b0;
      out_sat_reg     <= 1'b0;
    end else begin
      out_c_valid_reg <= sum_valid_reg;
      if (sum_valid_reg) begin
        out_c_reg   <= req_res;
        out_ovf_reg <= sum_ovf_reg;
        out_sat_reg <= req_sat;
      end
    end
  end

  assign bus.out_valid   = out_valid_reg;
  assign bus.out_a       = out_a_reg;
  assign bus.out_b       = out_b_reg;
  assign bus.out_last    = out_last_reg;
  assign bus.out_c_valid = out_c_valid_reg;
  assign bus.out_c       = out_c_reg;
  assign bus.out_ovf     = out_ovf_reg;
  assign bus.out_sat     = out_sat_reg;
endmodule

// File: tb/tb_systolic_pe_acc.sv
// Bench for systolic_pe_acc: two instances (AWIDTH 32 and 16) share one
// stimulus stream; a vector-level model predicts every output each cycle.
module tb_systolic_pe_acc;
  localparam int DW = 8;
  localparam int SW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          drv_rst = 1'b0;
  logic          drv_sg  = 1'b0;
  logic [SW-1:0] drv_sh  = '0;
  logic          drv_clr = 1'b0;
  logic          drv_v   = 1'b0;
  logic [DW-1:0] drv_a   = '0;
  logic [DW-1:0] drv_b   = '0;
  logic          drv_l   = 1'b0;

  systolic_pe_acc_if #(.DWIDTH(DW), .SHW(SW)) ifc32 ();
  systolic_pe_acc_if #(.DWIDTH(DW), .SHW(SW)) ifc16 ();

  assign ifc32.cfg_signed = drv_sg;  assign ifc16.cfg_signed = drv_sg;
  assign ifc32.cfg_shift  = drv_sh;  assign ifc16.cfg_shift  = drv_sh;
  assign ifc32.cfg_clear  = drv_clr; assign ifc16.cfg_clear  = drv_clr;
  assign ifc32.in_valid   = drv_v;   assign ifc16.in_valid   = drv_v;
  assign ifc32.in_a       = drv_a;   assign ifc16.in_a       = drv_a;
  assign ifc32.in_b       = drv_b;   assign ifc16.in_b       = drv_b;
  assign ifc32.in_last    = drv_l;   assign ifc16.in_last    = drv_l;

  systolic_pe_acc #(.DWIDTH(DW), .AWIDTH(32), .SHW(SW)) dut32 (
    .clk(clk), .reset(drv_rst), .bus(ifc32));
  systolic_pe_acc #(.DWIDTH(DW), .AWIDTH(16), .SHW(SW)) dut16 (
    .clk(clk), .reset(drv_rst), .bus(ifc16));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    longint c;
    bit     ovf;
    bit     sat;
    int     due;
  } res_t;

  function automatic longint wrapv(input longint v, input int aw, input bit sg);
    longint span, m;
    span = longint'(1) << aw;
    m = v & (span - 1);
    if (sg && m >= (span >>> 1)) m = m - span;
    return m;
  endfunction

  task automatic requant(input longint s, input int sh, input bit sg,
                         output longint c8, output bit sat);
    longint r, lo, hi;
    r   = (sh == 0) ? s : ((s + (longint'(1) << (sh - 1))) >>> sh);
    lo  = sg ? -(longint'(1) << (DW - 1)) : 0;
    hi  = sg ? (longint'(1) << (DW - 1)) - 1 : (longint'(1) << DW) - 1;
    sat = 1'b0;
    if (r > hi) begin r = hi; sat = 1'b1; end
    if (r < lo) begin r = lo; sat = 1'b1; end
    c8 = r & ((longint'(1) << DW) - 1);
  endtask

  // Compare process: snapshot inputs at the edge, advance the model, then
  // check both instances on the falling edge.
  initial begin
    int     cyc;
    int     aw[2];
    longint acc[2];
    bit     movf[2];
    bit     pv[2];
    longint pp[2];
    bit     pl[2];
    res_t   q0[$];
    res_t   q1[$];
    res_t   r;
    bit     e_cv[2];
    longint e_c[2];
    bit     e_ovf[2];
    bit     e_sat[2];
    bit     e_ov, e_ol;
    longint e_oa, e_ob;
    bit     s_rst, s_v, s_l, s_clr, s_sg;
    int     s_sh;
    logic [DW-1:0] s_a, s_b;
    longint s, ws, c8;
    bit     sat1;
    longint o[2][8];
    string  pfx;
    cyc = 0;
    aw[0] = 32; aw[1] = 16;
    e_ov = 0; e_ol = 0; e_oa = 0; e_ob = 0;
    for (int k = 0; k < 2; k++) begin
      acc[k] = 0; movf[k] = 0; pv[k] = 0; pp[k] = 0; pl[k] = 0;
      e_cv[k] = 0; e_c[k] = 0; e_ovf[k] = 0; e_sat[k] = 0;
    end
    forever begin
      @(posedge clk);
      s_rst = drv_rst; s_v = drv_v; s_a = drv_a; s_b = drv_b; s_l = drv_l;
      s_clr = drv_clr; s_sg = drv_sg; s_sh = int'(drv_sh);
      @(negedge clk);
      cyc++;
      if (!s_rst) begin
        e_ov = 0; e_oa = 0; e_ob = 0; e_ol = 0;
      end else begin
        e_ov = s_v;
        if (s_v) begin e_oa = longint'(s_a); e_ob = longint'(s_b); e_ol = s_l; end
      end
      for (int k = 0; k < 2; k++) begin
        if (!s_rst) begin
          acc[k] = 0; movf[k] = 0; pv[k] = 0;
          if (k == 0) q0.delete(); else q1.delete();
          e_cv[k] = 0; e_c[k] = 0; e_ovf[k] = 0; e_sat[k] = 0;
        end else begin
          e_cv[k] = 0;
          if (k == 0 && q0.size() > 0 && q0[0].due == cyc) begin
            r = q0.pop_front(); e_cv[k] = 1; e_c[k] = r.c; e_ovf[k] = r.ovf; e_sat[k] = r.sat;
          end
          if (k == 1 && q1.size() > 0 && q1[0].due == cyc) begin
            r = q1.pop_front(); e_cv[k] = 1; e_c[k] = r.c; e_ovf[k] = r.ovf; e_sat[k] = r.sat;
          end
          if (s_clr) begin
            acc[k] = 0; movf[k] = 0; pv[k] = 0;
          end else begin
            if (pv[k]) begin
              s  = acc[k] + pp[k];
              ws = wrapv(s, aw[k], s_sg);
              if (ws != s) movf[k] = 1;
              if (pl[k]) begin
                requant(ws, s_sh, s_sg, c8, sat1);
                r.c = c8; r.ovf = movf[k]; r.sat = sat1; r.due = cyc + 1;
                if (k == 0) q0.push_back(r); else q1.push_back(r);
                acc[k] = 0; movf[k] = 0;
              end else begin
                acc[k] = ws;
              end
            end
            pv[k] = s_v;
            if (s_v) begin
              pp[k] = s_sg ? longint'($signed(s_a)) * longint'($signed(s_b))
                           : longint'(s_a) * longint'(s_b);
              pl[k] = s_l;
            end
          end
        end
      end
      o[0][0] = longint'(ifc32.out_valid);   o[1][0] = longint'(ifc16.out_valid);
      o[0][1] = longint'(ifc32.out_a);       o[1][1] = longint'(ifc16.out_a);
      o[0][2] = longint'(ifc32.out_b);       o[1][2] = longint'(ifc16.out_b);
      o[0][3] = longint'(ifc32.out_last);    o[1][3] = longint'(ifc16.out_last);
      o[0][4] = longint'(ifc32.out_c_valid); o[1][4] = longint'(ifc16.out_c_valid);
      o[0][5] = longint'(ifc32.out_c);       o[1][5] = longint'(ifc16.out_c);
      o[0][6] = longint'(ifc32.out_ovf);     o[1][6] = longint'(ifc16.out_ovf);
      o[0][7] = longint'(ifc32.out_sat);     o[1][7] = longint'(ifc16.out_sat);
      for (int k = 0; k < 2; k++) begin
        pfx = (k == 0) ? "a32." : "a16.";
        chk({pfx, "out_valid"},   o[k][0], longint'(e_ov));
        chk({pfx, "out_a"},       o[k][1], e_oa);
        chk({pfx, "out_b"},       o[k][2], e_ob);
        chk({pfx, "out_last"},    o[k][3], longint'(e_ol));
        chk({pfx, "out_c_valid"}, o[k][4], longint'(e_cv[k]));
        chk({pfx, "out_c"},       o[k][5], e_c[k]);
        chk({pfx, "out_ovf"},     o[k][6], longint'(e_ovf[k]));
        chk({pfx, "out_sat"},     o[k][7], longint'(e_sat[k]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input bit l, input bit clr);
    drv_v = v; drv_a = a; drv_b = b; drv_l = l; drv_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic chk_res(input string nm, input longint c32, input bit o32, input bit s32,
                         input longint c16, input bit o16, input bit s16);
    chk({nm, ".cv32"}, longint'(ifc32.out_c_valid), 1);
    chk({nm, ".c32"},  longint'(ifc32.out_c), c32);
    chk({nm, ".ovf32"}, longint'(ifc32.out_ovf), longint'(o32));
    chk({nm, ".sat32"}, longint'(ifc32.out_sat), longint'(s32));
    chk({nm, ".cv16"}, longint'(ifc16.out_c_valid), 1);
    chk({nm, ".c16"},  longint'(ifc16.out_c), c16);
    chk({nm, ".ovf16"}, longint'(ifc16.out_ovf), longint'(o16));
    chk({nm, ".sat16"}, longint'(ifc16.out_sat), longint'(s16));
  endtask

  initial begin
    logic [DW-1:0] ra, rb;
    // reset state, with live-looking inputs
    drive(1'b1, 8'd5, 8'd6, 1'b1, 1'b0);
    chk("rst.out_valid", longint'(ifc32.out_valid), 0);
    chk("rst.out_a", longint'(ifc32.out_a), 0);
    chk("rst.out_c_valid", longint'(ifc32.out_c_valid), 0);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    chk("rst.out_c", longint'(ifc16.out_c), 0);
    drv_rst = 1'b1;
    idle();

    // T1 signed dot product {2,-3,4}.{5,6,-1} = -12
    drv_sg = 1'b1; drv_sh = '0;
    drive(1'b1, 8'd2, 8'd5, 1'b0, 1'b0);
    chk("t1.fwd_a", longint'(ifc32.out_a), 2);
    chk("t1.fwd_b", longint'(ifc32.out_b), 5);
    drive(1'b1, 8'hFD, 8'd6, 1'b0, 1'b0);
    drive(1'b1, 8'd4, 8'hFF, 1'b1, 1'b0);
    chk("t1.fwd_last", longint'(ifc32.out_last), 1);
    idle();
    chk("t1.early_cv", longint'(ifc32.out_c_valid), 0);
    idle();
    chk_res("t1", 8'hF4, 0, 0, 8'hF4, 0, 0);
    idle();

    // T2 unsigned 200*200 >> 4 saturates to 255
    drv_sg = 1'b0; drv_sh = 5'd4;
    drive(1'b1, 8'd200, 8'd200, 1'b1, 1'b0);
    idle(); idle();
    chk_res("t2", 255, 0, 1, 255, 0, 1);
    idle();

    // T3 back-to-back single-element vectors
    drv_sg = 1'b1; drv_sh = '0;
    drive(1'b1, 8'd1, 8'd1, 1'b1, 1'b0);
    drive(1'b1, 8'd3, 8'd3, 1'b1, 1'b0);
    idle();
    chk_res("t3a", 1, 0, 0, 1, 0, 0);
    idle();
    chk_res("t3b", 9, 0, 0, 9, 0, 0);
    idle();

    // T4 3 x 127*127: wraps the 16-bit accumulator only
    drive(1'b1, 8'd127, 8'd127, 1'b0, 1'b0);
    drive(1'b1, 8'd127, 8'd127, 1'b0, 1'b0);
    drive(1'b1, 8'd127, 8'd127, 1'b1, 1'b0);
    drive(1'b1, 8'd1, 8'd1, 1'b1, 1'b0);
    idle();
    chk_res("t4a", 8'h7F, 0, 1, 8'h80, 1, 1);
    idle();
    chk_res("t4b", 1, 0, 0, 1, 0, 0);
    idle();

    // T5 clear mid-vector, input on the clear cycle is dropped
    drive(1'b1, 8'd2, 8'd2, 1'b0, 1'b0);
    drive(1'b1, 8'd3, 8'd3, 1'b0, 1'b0);
    drive(1'b1, 8'd9, 8'd9, 1'b0, 1'b1);
    chk("t5.fwd_a", longint'(ifc32.out_a), 9);
    chk("t5.fwd_valid", longint'(ifc32.out_valid), 1);
    drive(1'b1, 8'd4, 8'd4, 1'b1, 1'b0);
    idle();
    chk("t5.no_early", longint'(ifc32.out_c_valid), 0);
    idle();
    chk_res("t5", 16, 0, 0, 16, 0, 0);
    idle();

    // T6 reset mid-vector
    drive(1'b1, 8'd6, 8'd6, 1'b0, 1'b0);
    drive(1'b1, 8'd7, 8'd7, 1'b0, 1'b0);
    drv_rst = 1'b0;
    drive(1'b1, 8'd8, 8'd8, 1'b1, 1'b0);
    chk("t6.out_valid", longint'(ifc32.out_valid), 0);
    chk("t6.out_a", longint'(ifc32.out_a), 0);
    chk("t6.out_c", longint'(ifc32.out_c), 0);
    drive(1'b1, 8'd8, 8'd8, 1'b1, 1'b0);
    chk("t6.out_c_valid", longint'(ifc32.out_c_valid), 0);
    drv_rst = 1'b1;
    drive(1'b1, 8'd5, 8'd5, 1'b1, 1'b0);
    idle();
    chk("t6.no_stale", longint'(ifc32.out_c_valid), 0);
    idle();
    chk_res("t6", 25, 0, 0, 25, 0, 0);
    idle();

    // Randomised segments; config changes only once the pipe is flushed.
    for (int seg = 0; seg < 12; seg++) begin
      drv_sg = 1'($urandom_range(0, 1));
      drv_sh = ($urandom_range(0, 1) == 0) ? SW'($urandom_range(0, 6))
                                            : SW'($urandom_range(0, 31));
      for (int i = 0; i < 250; i++) begin
        case ($urandom_range(0, 4))
          0: ra = 8'h7F;
          1: ra = 8'h80;
          default: ra = DW'($urandom_range(0, 255));
        endcase
        case ($urandom_range(0, 4))
          0: rb = 8'hFF;
          1: rb = 8'h80;
          default: rb = DW'($urandom_range(0, 255));
        endcase
        drv_rst = ($urandom_range(0, 99) != 0);
        drive($urandom_range(0, 99) < 70, ra, rb,
              $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 3);
      end
      drv_rst = 1'b1;
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      repeat (3) idle();
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/systolic_pe_acc.md
Name: systolic_pe_acc

Overview:
- Parametrised next-generation systolic processing element for the TPU array. Width-generic and valid-qualified.
- Forwards A east and B south through one register stage each.
- Accumulates A×B products into a wide accumulator over a vector delimited by in_last.
- Emits a requantised (shift, round, saturate) DWIDTH result with its own valid pulse plus overflow/saturation flags. Replaces the fixed-8-bit free-running MAC PE.

Parameters:
- DWIDTH, 8, operand and output data width.
- AWIDTH, 32, accumulator width; must be ≥ 2*DWIDTH.
- SHW, 5, width of cfg_shift.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- cfg_signed  in  1  1 = two's-complement operands and output; 0 = unsigned. Static while any valid is in flight.
- cfg_shift  in  SHW  right-shift applied at requantisation. Static while any valid is in flight.
- cfg_clear  in  1  synchronous flush of partial sum and product stage.
- in_valid  in  1  in_a/in_b/in_last qualified.
- in_a  in  DWIDTH  west operand.
- in_b  in  DWIDTH  north operand.
- in_last  in  1  final element of the current dot product.
- out_valid  out  1  registered copy of in_valid (forward path).
- out_a  out  DWIDTH  registered in_a.
- out_b  out  DWIDTH  registered in_b.
- out_last  out  1  registered in_last.
- out_c_valid  out  1  one-cycle pulse, out_c valid.
- out_c  out  DWIDTH  requantised result.
- out_ovf  out  1  accumulator overflowed during this vector; valid with out_c_valid.
- out_sat  out  1  requantisation saturated; valid with out_c_valid.

Behaviour:
- Reset (reset==0 at a clock edge): every output is 0, the accumulator is 0, all pipeline valids are 0, and the FSM is IDLE. Reset mid-vector discards all partial state with no output.
- Forward path:
  - Latency 1: out_valid/out_a/out_b/out_last take the in_* values at every edge.
  - Data registers update only when in_valid=1, so they hold when invalid; out_valid always updates.
  - The forward path is unaffected by cfg_clear.
- S1 (product):
  - When in_valid, p = in_a*in_b, signed or unsigned per cfg_signed, 2*DWIDTH bits.
  - p is registered with p_valid and p_last.
- S2 (accumulate), FSM states:
  - IDLE: acc==0, no vector open.
  - ACCUM: partial sum open.
  - On p_valid & !p_last: acc <= base + p_ext. base = 0 in IDLE, acc in ACCUM. Next state is ACCUM.
  - On p_valid & p_last: sum = base + p_ext is captured into the result stage. acc <= 0 and the state returns to IDLE.
  - A back-to-back next vector starts in the following cycle with no bubble.
  - p_ext is the sign/zero extension of p to AWIDTH. The accumulator wraps modulo 2^AWIDTH.
  - ovf_sticky sets on signed (or unsigned carry-out) overflow of any add in the vector, including the last one. It clears when the result is captured.
- S3 (requant, sub-module):
  - r = (sum + (cfg_shift>0 ? 1<<(cfg_shift-1) : 0)) >>> cfg_shift. The shift is arithmetic when signed, logical when unsigned. Rounding is half-up; rounding overflow is evaluated at AWIDTH+1 bits.
  - Saturation bounds: signed [-2^(DWIDTH-1), 2^(DWIDTH-1)-1]; unsigned [0, 2^DWIDTH-1]. out_sat=1 if clamped.
  - out_c/out_ovf/out_sat update only with out_c_valid and hold otherwise.
- Latency: a last element presented in cycle t produces out_c_valid high in cycle t+3.
- A single-element vector (in_last on the first valid) is legal.
- Invalid cycles inside a vector are legal gaps; they leave acc and the FSM unchanged.
- cfg_clear, highest priority after reset:
  - p_valid <= 0, acc <= 0, ovf_sticky <= 0, state <= IDLE.
  - An in_valid in the same cycle is dropped. A result already in S3 still emits.
- in_last with in_valid=0 is ignored.

Decomposition:
- Package systolic_pe_pkg holds: FSM state encoding (IDLE=0, ACCUM=1); the default widths DWIDTH/AWIDTH/SHW; and a function for the signed/unsigned saturation bounds.
- One sub-module, pe_requant: combinational round/shift/saturate of AWIDTH to DWIDTH, producing out_sat. The registers live in systolic_pe_acc.

Test Plan:
- Signed, shift 0. Vector a={2,-3,4}, b={5,6,-1}, last on the third element. Expect out_c_valid 3 cycles after the third element, out_c=-12 (0xF4), ovf=0, sat=0. out_a/out_b follow the inputs 1 cycle later.
- Unsigned, shift 4. a=200,b=200 single element, sum=40000, r=(40000+8)>>4=2500. Expect out_c=255, sat=1.
- Back-to-back vectors {1×1,last} then {3×3,last} in consecutive cycles. Expect out_c=1 then 9 on consecutive cycles, with no accumulator carry-over.
- AWIDTH=16, signed: 3 elements of 127×127 (sum wraps past 32767). Expect ovf=1 with the result, and ovf=0 on the next vector {1×1}.
- cfg_clear asserted after 2 elements of a vector, then {4×4,last}. Expect a single out_c=16; forwarded outputs are unchanged by the clear.
- Drive reset=0 mid-vector, release, then send {5×5,last}. Expect all outputs 0 during reset, then out_c=25. No result is ever produced for the interrupted vector.
